// File: rtl/i2s_serializer.sv
// I2S transmitter: prefetches 32-bit stereo words from a FIFO and shifts them out
// MSB first, left sample with WS=0 and right sample with WS=1.
module i2s_serializer #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] fifo_out_data,
  input  logic        fifo_out_rts,
  output logic        fifo_out_rtr,
  output logic        i2s_sck,
  output logic        i2s_ws,
  output logic        i2s_sd,
  output logic        underrun
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  typedef enum logic [1:0] {F_IDLE, F_REQ, F_CAP} pf_state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t    r_state, w_state_next;
  pf_state_t r_pf, w_pf_next;

  logic [7:0]  r_div_cnt;
  logic [4:0]  r_bit_cnt;
  logic [31:0] r_shift, r_hold;
  logic        r_hold_valid, r_sck, r_ws, r_sd, r_underrun;

  logic        w_div_wrap, w_fall, w_start, w_bit_event, w_stop, w_load, w_cap;
  logic        w_ws_next, w_sd_next;
  logic [31:0] w_load_word;

  always_comb begin
    w_div_wrap  = (r_div_cnt == DIV_LAST);
    w_fall      = (r_state == RUN) && r_sck && w_div_wrap;
    w_start     = (r_state == PRIME) && r_hold_valid;
    w_bit_event = w_start || w_fall;
    // A frame boundary with enable low ends the run instead of loading a word.
    w_stop      = w_fall && (r_bit_cnt == 5'd0) && !enable;
    w_load      = w_bit_event && (r_bit_cnt == 5'd0) && !w_stop;
    w_cap       = (r_pf == F_CAP);
    w_load_word = r_hold_valid ? r_hold : (w_cap ? fifo_out_data : 32'd0);
    w_ws_next   = (r_bit_cnt >= 5'd15) && (r_bit_cnt <= 5'd30);
    w_sd_next   = w_load ? w_load_word[31] : r_shift[5'd31 - r_bit_cnt];
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (enable) w_state_next = PRIME;
      PRIME: begin
        if (r_hold_valid) w_state_next = RUN;
        else if (!enable) w_state_next = IDLE;
      end
      RUN:     if (w_stop) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_pf_next = r_pf;
    case (r_pf)
      F_IDLE: if ((r_state != IDLE) && !r_hold_valid && fifo_out_rts) w_pf_next = F_REQ;
      F_REQ:   w_pf_next = F_CAP;
      F_CAP:   w_pf_next = F_IDLE;
      default: w_pf_next = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_pf    <= F_IDLE;
    end else begin
      r_state <= w_state_next;
      r_pf    <= w_pf_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_sck        <= 1'b0;
      r_ws         <= 1'b0;
      r_sd         <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_underrun <= w_load && !r_hold_valid && !w_cap;

      // A word captured on the same cycle it is needed goes straight to the shifter.
      if (w_load && r_hold_valid) begin
        r_hold_valid <= 1'b0;
      end else if (w_cap) begin
        r_hold <= fifo_out_data;
        if (!w_load) r_hold_valid <= 1'b1;
      end

      if (w_load) r_shift <= w_load_word;

      if ((r_state != RUN) || w_stop) begin
        r_div_cnt <= '0;
        r_sck     <= 1'b0;
      end else if (w_div_wrap) begin
        r_div_cnt <= '0;
        r_sck     <= ~r_sck;
      end else begin
        r_div_cnt <= r_div_cnt + 8'd1;
      end

      if (w_stop) begin
        r_bit_cnt <= '0;
        r_ws      <= 1'b0;
        r_sd      <= 1'b0;
      end else if (w_bit_event) begin
        r_bit_cnt <= r_bit_cnt + 5'd1;
        r_ws      <= w_ws_next;
        r_sd      <= w_sd_next;
      end else if (r_state != RUN) begin
        r_bit_cnt <= '0;
        r_ws      <= 1'b0;
        r_sd      <= 1'b0;
      end
    end
  end

  // Gated by reset so no pop can complete while reset is held.
  assign fifo_out_rtr = (r_pf == F_REQ) && rst;
  assign i2s_sck      = r_sck;
  assign i2s_ws       = r_ws;
  assign i2s_sd       = r_sd;
  assign underrun     = r_underrun;

endmodule
